// File: rtl/instr_fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eighty_twos_pkg
//  Description : Shared types, constants and the opcode-length decode for the
//                EightyTwos instruction fetch path.
//  Revision    : 1.0 - initial release
// ============================================================================
package eighty_twos_pkg;

    // Fetch/sequence state encoding
    typedef enum logic [2:0] {
        ST_F1   = 3'd0,
        ST_F2   = 3'd1,
        ST_F3   = 3'd2,
        ST_EXEC = 3'd3,
        ST_HALT = 3'd4
    } fetch_state_t;

    localparam logic [7:0] HLT_OPCODE_DEFAULT = 8'h76;

    // Instruction length codes
    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;
    localparam logic [1:0] LEN_3 = 2'd3;

    // Instruction length from the opcode byte; earlier rules take priority.
    function automatic logic [1:0] instr_len(input logic [7:0] op);
        logic [1:0] len;
        len = LEN_1;
        if (op[7:6] == 2'b11 && op[2:1] == 2'b01) begin
            len = LEN_3;                         // jump
        end else if (op[7:6] == 2'b11 && op[2:1] == 2'b11) begin
            len = LEN_2;                         // immediate ALU
        end else if (op[7:6] == 2'b00 && op[3:0] == 4'b0001) begin
            len = LEN_3;                         // LXI
        end else if (op[7:6] == 2'b00 && op[5] && op[2:0] == 3'b010) begin
            len = LEN_3;                         // SHLD/LHLD/STA/LDA
        end else if (op[7:6] == 2'b00 && op[2:0] == 3'b110) begin
            len = LEN_2;                         // MVI
        end
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_sequencer_if
//  Description : Byte-wide memory read bus between the fetch sequencer
//                (master) and the memory system (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_sequencer_if;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        mem_rd;
    logic [15:0] mem_addr;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_sequencer
//  Description : Fetches 1-3 byte instructions over the byte-wide memory bus,
//                presents the assembled word to the decoder during EXEC, and
//                owns the program counter (advance, jump redirect, halt).
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_sequencer
    import eighty_twos_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [7:0]  HLT_OPCODE = HLT_OPCODE_DEFAULT
) (
    input  wire logic               clk,
    input  wire logic               nRst,
    instr_fetch_sequencer_if.master mem,
    output logic [23:0]             instr,
    output logic [1:0]              num_bytes,
    output logic                    instr_valid,
    input  wire logic               exec_busy,
    input  wire logic               jump_taken,
    input  wire logic [15:0]        jump_target,
    output logic [15:0]             pc,
    output logic                    halted
);

    fetch_state_t state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [23:0]  instr_q, instr_d;
    logic [1:0]   num_bytes_q, num_bytes_d;

    logic         w_mem_rd;
    logic [15:0]  w_mem_addr;
    logic [1:0]   w_op_len;

    // Next-state, pc/instr update and bus request decode (bus outputs use state only)
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        num_bytes_d = num_bytes_q;
        w_mem_rd    = 1'b0;
        w_mem_addr  = 16'h0000;
        w_op_len    = instr_len(mem.mem_rdata);

        case (state_q)
            ST_F1: begin
                w_mem_rd   = 1'b1;
                w_mem_addr = pc_q;
                if (mem.mem_ack) begin
                    instr_d     = {mem.mem_rdata, 16'h0000};
                    num_bytes_d = w_op_len;
                    if (mem.mem_rdata == HLT_OPCODE) begin
                        state_d = ST_HALT;
                    end else if (w_op_len != LEN_1) begin
                        state_d = ST_F2;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_F2: begin
                w_mem_rd   = 1'b1;
                w_mem_addr = pc_q + 16'd1;
                if (mem.mem_ack) begin
                    instr_d[15:8] = mem.mem_rdata;
                    state_d       = (num_bytes_q == LEN_3) ? ST_F3 : ST_EXEC;
                end
            end
            ST_F3: begin
                w_mem_rd   = 1'b1;
                w_mem_addr = pc_q + 16'd2;
                if (mem.mem_ack) begin
                    instr_d[7:0] = mem.mem_rdata;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Jump decision only counts on the cycle the datapath releases
                if (!exec_busy) begin
                    pc_d    = jump_taken ? jump_target : (pc_q + {14'd0, num_bytes_q});
                    state_d = ST_F1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_F1;
            end
        endcase
    end

    // State, program counter and instruction registers
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= ST_F1;
            pc_q        <= RESET_PC;
            instr_q     <= 24'h000000;
            num_bytes_q <= LEN_1;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            num_bytes_q <= num_bytes_d;
        end
    end

    // Read request is forced low while reset is held, since state sits in F1
    assign mem.mem_rd   = w_mem_rd & nRst;
    assign mem.mem_addr = w_mem_addr;
    assign instr        = instr_q;
    assign num_bytes    = num_bytes_q;
    assign pc           = pc_q;
    assign instr_valid  = (state_q == ST_EXEC);
    assign halted       = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: doc/instr_fetch_sequencer.md
# instr_fetch_sequencer

Fetch/sequence controller for the EightyTwos core. Reads a 1–3 byte instruction from the byte-wide memory bus, assembles the 24-bit word and byte count presented to the instruction decoder, then holds an execute phase. Owns the program counter, including sequential advance, jump redirect and halt. Sits between the memory bus, the decoder and the register/ALU datapath.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- HLT_OPCODE, 8'h76, opcode byte that enters HALT

Ports:
- clk  in  1  system clock
- nRst  in  1  reset; asynchronous, active-low
- mem_rdata  in  8  read data; valid in the cycle mem_ack=1
- mem_ack  in  1  completes the current read
- mem_rd  out  1  read request; held until acked
- mem_addr  out  16  byte address of the current read
- instr  out  24  assembled instruction: [23:16] opcode byte, [15:8] byte 2, [7:0] byte 3
- num_bytes  out  2  instruction length: 1, 2 or 3
- instr_valid  out  1  high for every cycle in EXEC
- exec_busy  in  1  datapath stall; EXEC holds while high
- jump_taken  in  1  sampled on the last EXEC cycle; redirects PC
- jump_target  in  16  new PC when jump_taken=1
- pc  out  16  address of the current instruction's opcode byte
- halted  out  1  high in HALT

## Operation
- States: F1 (opcode), F2 (byte 2), F3 (byte 3), EXEC, HALT.
- Reset, asynchronous and immediate, including mid-fetch or mid-exec:
  - state=F1, pc=RESET_PC, instr=0, num_bytes=1.
  - mem_rd=0 during reset; mem_rd=1 from the first cycle after release.
  - instr_valid=0, halted=0.
- mem_rd=1 in F1, F2 and F3 only; 0 in EXEC and HALT.
- mem_addr:
  - F1: pc
  - F2: pc+1
  - F3: pc+2
  - all 16-bit wraparound; 0 in EXEC and HALT.
- F1, on ack:
  - instr[23:16] ← rdata; instr[15:0] ← 0.
  - num_bytes ← len(rdata).
  - Next: F2 if len>1, else EXEC.
  - If rdata==HLT_OPCODE, next is HALT (no EXEC).
- F2, on ack: instr[15:8] ← rdata. Next: F3 if num_bytes==3, else EXEC.
- F3, on ack: instr[7:0] ← rdata. Next: EXEC.
- No ack: state holds, mem_rd and mem_addr stay stable. mem_ack outside F states is ignored.
- EXEC:
  - Stays while exec_busy=1.
  - On the first cycle with exec_busy=0:
    - pc ← jump_taken ? jump_target : pc+num_bytes (mod 2^16).
    - Next: F1.
  - jump_taken while exec_busy=1 is ignored.
- HALT: absorbing; only reset exits. pc is frozen at the HLT address.
- len(op), in priority order:
  - op[7:6]=11, op[2:1]=01 (jump): 3
  - op[7:6]=11, op[2:1]=11 (immediate ALU): 2
  - op[7:6]=00, op[3:0]=0001 (LXI): 3
  - op[7:6]=00, op[5]=1, op[2:0]=010 (SHLD/LHLD/STA/LDA): 3
  - op[7:6]=00, op[2:0]=110 (MVI): 2
  - otherwise: 1

## Timing
- All state, pc and instr registers update on the rising clk edge.
- mem_rd and mem_addr are decoded from registered state only, with no comb path from mem_ack.
- Zero-wait memory (ack in the same cycle as rd):
  - 1-byte instruction: 2 cycles
  - 2-byte: 3 cycles
  - 3-byte: 4 cycles
- Each wait cycle adds 1.
- instr and num_bytes are stable for the whole EXEC phase.
- Simultaneous jump_taken with a PC at 16'hFFFF: jump_target wins.
- Back-to-back instructions: F1 of the next instruction is the cycle after the final EXEC cycle.

## Structure
- Package eighty_twos_pkg holds:
  - fetch_state_t enum
  - HLT_OPCODE default
  - length codes
  - function instr_len(logic [7:0]) returning logic [1:0]
- The decoder and its testbench use the same function.
- No sub-module. One always_ff for state/pc/instr, one always_comb for next-state and bus outputs.

## Test plan
- Reset release, memory 00h at 0000h, zero-wait, no busy:
  - mem_rd=1 with addr 0000h on cycle 1.
  - EXEC on cycle 2, instr=000000h, num_bytes=1.
  - pc=0001h on cycle 3.
- LXI at 0010h (01h,34h,12h), 2 wait cycles per byte:
  - Addresses 0010h/0011h/0012h each held 3 cycles.
  - instr=013412h, num_bytes=3, next pc=0013h.
- Jump C3h,00h,20h at 0100h, jump_taken=1, target 2000h, exec_busy=1 for 2 cycles:
  - EXEC lasts 3 cycles.
  - Next mem_addr=2000h.
- MVI 3Eh,55h at FFFFh:
  - Byte-2 read at 0000h.
  - instr=3E5500h, next pc=0001h.
- Opcode 76h at 0040h:
  - halted=1, mem_rd=0, pc=0040h held for 20 cycles.
  - nRst pulse returns state to F1 at RESET_PC.
- nRst asserted mid-F2 of a 3-byte fetch:
  - mem_rd drops and pc=RESET_PC in the same cycle, without a clock edge.
  - Refetch restarts cleanly.
